// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three buses around the memory port arbiter:
//   I-cache port : i_read, i_address -> i_rdata, i_resp
//   D-cache port : d_read, d_write, d_address, d_wdata -> d_rdata, d_resp
//   Memory port  : pmem_read, pmem_write, pmem_address, pmem_wdata
//                  <- pmem_rdata, pmem_resp
// Modports:
//   slave  - the arbiter (takes cache requests, drives physical memory)
//   master - the surrounding environment (caches + physical memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    // I-cache side
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    // Physical memory side
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_address,
        output i_rdata, i_resp,
        input  d_read, d_write, d_address, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_address,
        input  i_rdata, i_resp,
        output d_read, d_write, d_address, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one physical memory port between an I-cache (line fills) and a
// D-cache (line fills and writebacks). One transaction in flight at a time;
// contention in IDLE is resolved round robin against the last granted side.
// All outputs come straight from flops.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - mem_port_arbiter_if.slave (cache request ports + memory port)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I_BUSY,
        ST_D_BUSY,
        ST_I_DONE,
        ST_D_DONE
    } state_t;

    // last_grant encoding: 0 = I-cache, 1 = D-cache
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t            state_q,        state_d;
    logic              last_grant_q,   last_grant_d;
    logic              pmem_read_q,    pmem_read_d;
    logic              pmem_write_q,   pmem_write_d;
    logic [ADDR_W-1:0] addr_q,         addr_d;
    logic [LINE_W-1:0] wdata_q,        wdata_d;
    logic [LINE_W-1:0] line_q,         line_d;
    logic              i_resp_q,       i_resp_d;
    logic              d_resp_q,       d_resp_d;

    logic i_req;
    logic d_req;
    logic grant_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        line_d       = line_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;

        i_req   = bus.i_read;
        d_req   = bus.d_read | bus.d_write;
        // D wins when it is alone, or on contention when I had the last grant.
        grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));

        case (state_q)
            ST_IDLE: begin
                if (grant_d) begin
                    state_d      = ST_D_BUSY;
                    last_grant_d = GRANT_D;
                    addr_d       = bus.d_address;
                    wdata_d      = bus.d_wdata;
                    // A simultaneous read+write is taken as the writeback.
                    pmem_write_d = bus.d_write;
                    pmem_read_d  = ~bus.d_write;
                end else if (i_req) begin
                    state_d      = ST_I_BUSY;
                    last_grant_d = GRANT_I;
                    addr_d       = bus.i_address;
                    pmem_read_d  = 1'b1;
                end
            end
            ST_I_BUSY: begin
                if (bus.pmem_resp) begin
                    state_d     = ST_I_DONE;
                    pmem_read_d = 1'b0;
                    line_d      = bus.pmem_rdata;
                    i_resp_d    = 1'b1;
                end
            end
            ST_D_BUSY: begin
                if (bus.pmem_resp) begin
                    state_d      = ST_D_DONE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    line_d       = bus.pmem_rdata;
                    d_resp_d     = 1'b1;
                end
            end
            // The resp pulse is visible during DONE; requests are not looked
            // at here, so a still-high request is re-sampled in IDLE.
            ST_I_DONE: state_d = ST_IDLE;
            ST_D_DONE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_I;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            line_q       <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            line_q       <= line_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.i_rdata      = line_q;
    assign bus.d_rdata      = line_q;
    assign bus.i_resp       = i_resp_q;
    assign bus.d_resp       = d_resp_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Inputs change and outputs are sampled
// on the falling edge; the bench plays the physical memory by hand.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();

    mem_port_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [255:0] LINE_A = {8{32'hA5A5_0001}};
    localparam logic [255:0] LINE_B = {8{32'hB0B0_1234}};
    localparam logic [255:0] LINE_C = {8{32'hC3C3_5678}};
    localparam logic [255:0] LINE_D = {8{32'hD00D_9ABC}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for a memory strobe, checks the latched request, holds
    // it for 'delay' cycles checking stability, then returns 'rdata' with a
    // one-cycle pmem_resp. Returns at the falling edge where x_resp is due.
    task automatic mem_txn(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [255:0] exp_wdata, input logic [255:0] rdata, input int delay);
        int n = 0;
        while (!(bus.pmem_read || bus.pmem_write) && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_strobe_seen"}, 256'(n < 8), 256'd1);
        chk({tag, "_op"}, {bus.pmem_read, bus.pmem_write}, exp_wr ? 2'b01 : 2'b10);
        chk({tag, "_addr"}, bus.pmem_address, exp_addr);
        if (exp_wr) chk({tag, "_wdata"}, bus.pmem_wdata, exp_wdata);
        for (int k = 0; k < delay; k++) begin
            tick();
            chk({tag, "_hold"}, {bus.pmem_read, bus.pmem_write, bus.pmem_address},
                {~exp_wr, exp_wr, exp_addr});
            chk({tag, "_noresp"}, {bus.i_resp, bus.d_resp}, 2'b00);
            if (exp_wr) chk({tag, "_wdata_hold"}, bus.pmem_wdata, exp_wdata);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rdata;
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        chk({tag, "_strobe_drop"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
        $display("txn %s wr=%0d addr=%h wait=%0d", tag, exp_wr, exp_addr, n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        bus.pmem_resp = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_read = 1'b0; bus.i_address = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        do_reset();

        // Reset state
        chk("rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("rst_resps", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("rst_addr", bus.pmem_address, 32'h0);
        chk("rst_wdata", bus.pmem_wdata, 256'h0);
        chk("rst_line", bus.i_rdata, 256'h0);

        // Solo I fill; address changed after grant must not leak through
        bus.i_read = 1'b1; bus.i_address = 32'h0000_1000;
        tick();
        chk("i_solo_latency", bus.pmem_read, 1'b1);
        bus.i_address = 32'hDEAD_BEEF;
        mem_txn("i_solo", 1'b0, 32'h0000_1000, '0, LINE_A, 3);
        chk("i_solo_resp", {bus.i_resp, bus.d_resp}, 2'b10);
        chk("i_solo_rdata", bus.i_rdata, LINE_A);
        bus.i_read = 1'b0;
        tick();
        chk("i_solo_pulse", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("i_solo_line_hold", bus.i_rdata, LINE_A);

        // Contention after reset: D first, then I
        do_reset();
        bus.i_read = 1'b1; bus.i_address = 32'h0000_3000;
        bus.d_read = 1'b1; bus.d_address = 32'h0000_4000;
        tick();
        mem_txn("cont_d", 1'b0, 32'h0000_4000, '0, LINE_B, 1);
        chk("cont_d_resp", {bus.i_resp, bus.d_resp}, 2'b01);
        chk("cont_d_rdata", bus.d_rdata, LINE_B);
        bus.d_read = 1'b0;
        mem_txn("cont_i", 1'b0, 32'h0000_3000, '0, LINE_C, 0);
        chk("cont_i_resp", {bus.i_resp, bus.d_resp}, 2'b10);
        chk("cont_i_rdata", bus.i_rdata, LINE_C);
        bus.i_read = 1'b0;
        tick();

        // Repeated contention: grants alternate D, I, D, I
        for (int r = 0; r < 4; r++) begin
            bus.i_read = 1'b1; bus.i_address = 32'h0001_0000 + 32'(r);
            bus.d_read = 1'b1; bus.d_address = 32'h0002_0000 + 32'(r);
            tick();
            if (r % 2 == 0) begin
                mem_txn("rr_d", 1'b0, 32'h0002_0000 + 32'(r), '0, LINE_D, 0);
                chk("rr_d_resp", {bus.i_resp, bus.d_resp}, 2'b01);
            end else begin
                mem_txn("rr_i", 1'b0, 32'h0001_0000 + 32'(r), '0, LINE_D, 0);
                chk("rr_i_resp", {bus.i_resp, bus.d_resp}, 2'b10);
            end
            bus.i_read = 1'b0; bus.d_read = 1'b0;
            tick();
        end

        // Writeback with d_read also high: write wins, pmem_read stays low
        bus.d_write = 1'b1; bus.d_read = 1'b1;
        bus.d_address = 32'h0000_2000; bus.d_wdata = LINE_B;
        tick();
        bus.d_wdata = LINE_C;
        mem_txn("d_wb", 1'b1, 32'h0000_2000, LINE_B, LINE_A, 2);
        chk("d_wb_resp", {bus.i_resp, bus.d_resp}, 2'b01);
        bus.d_write = 1'b0; bus.d_read = 1'b0;
        tick();

        // Reset during D_BUSY abandons the writeback; held request re-issues
        bus.d_write = 1'b1; bus.d_address = 32'h0000_5000; bus.d_wdata = LINE_C;
        tick();
        chk("rst_mid_busy", bus.pmem_write, 1'b1);
        rst = 1'b1;
        tick();
        chk("rst_mid_strobe", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("rst_mid_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("rst_mid_addr", bus.pmem_address, 32'h0);
        rst = 1'b0;
        mem_txn("rst_reissue", 1'b1, 32'h0000_5000, LINE_C, LINE_B, 1);
        chk("rst_reissue_resp", {bus.i_resp, bus.d_resp}, 2'b01);
        bus.d_write = 1'b0;
        tick();

        // Spurious pmem_resp in IDLE
        bus.pmem_resp = 1'b1; bus.pmem_rdata = LINE_D;
        tick();
        bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
        chk("spur_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        chk("spur_strobe", {bus.pmem_read, bus.pmem_write}, 2'b00);
        chk("spur_line", bus.d_rdata, LINE_B);
        bus.i_read = 1'b1; bus.i_address = 32'h0000_6000;
        tick();
        chk("spur_still_idle", bus.pmem_read, 1'b1);
        mem_txn("post_spur", 1'b0, 32'h0000_6000, '0, LINE_A, 0);
        chk("post_spur_resp", {bus.i_resp, bus.d_resp}, 2'b10);
        bus.i_read = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
